// File: rtl/type_pkg.sv
// Core-wide register-file types and the zero-register define.
// Shared by the ID-stage operand and hazard logic.
`ifndef ZeroReg
`define ZeroReg 5'd0
`endif

package type_pkg;

  localparam int RegWidth     = 32;
  localparam int RegAddrWidth = 5;
  localparam int NumRegs      = 32;

  typedef logic [RegWidth-1:0]     RegBus;
  typedef logic [RegAddrWidth-1:0] RegAddrBus;

  // Winning forwarding stage for one operand.
  typedef struct packed {
    logic  hit;
    logic  rdy;
    RegBus data;
  } fwd_sel_t;

endpackage

// File: rtl/fwd_port_mux.sv
// Per-read-port operand select and RAW hazard detection.
// Stage 0 is the youngest and wins over older stages.
`ifndef ZeroReg
`define ZeroReg 5'd0
`endif

module fwd_port_mux
  import type_pkg::*;
#(
  parameter int NUM_STAGES = 3
) (
  input  logic                  src_valid,
  input  RegAddrBus             src_addr,
  input  RegBus                 rf_rdata,
  output RegAddrBus             rf_raddr,
  output RegBus                 op_data,
  output logic                  hazard,
  input  logic [NUM_STAGES-1:0] fwd_valid,
  input  RegAddrBus [NUM_STAGES-1:0] fwd_addr,
  input  RegBus [NUM_STAGES-1:0]     fwd_data,
  input  logic [NUM_STAGES-1:0] fwd_rdy,
  input  logic                  lw_done,
  input  RegAddrBus             lw_addr,
  input  RegBus                 lw_data,
  input  logic [NumRegs-1:0]    busy
);

  fwd_sel_t sel;
  logic     is_zero;
  logic     lw_hit;
  logic     pick_fwd;
  logic     pick_lw;
  logic     use_rf;

  // Walk oldest to youngest so the youngest match is left standing.
  always_comb begin
    sel = '0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if (fwd_valid[s] && (fwd_addr[s] == src_addr)) begin
        sel.hit  = 1'b1;
        sel.rdy  = fwd_rdy[s];
        sel.data = fwd_data[s];
      end
    end
  end

  assign is_zero  = (src_addr == `ZeroReg);
  assign lw_hit   = lw_done && (lw_addr == src_addr);
  assign pick_fwd = !is_zero && sel.hit;
  assign pick_lw  = !is_zero && !sel.hit && lw_hit;
  assign use_rf   = !pick_fwd && !pick_lw;

  always_comb begin
    op_data = rf_rdata;
    unique case (1'b1)
      pick_fwd: op_data = sel.data;
      pick_lw:  op_data = lw_data;
      default:  op_data = rf_rdata;
    endcase
  end

  assign rf_raddr = use_rf ? src_addr : `ZeroReg;

  // Not-yet-produced stage data, or a pending long write nobody bypasses.
  assign hazard = src_valid &&
                  ((pick_fwd && !sel.rdy) ||
                   (!is_zero && busy[src_addr] &&
                    !sel.hit && !lw_hit));

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding, long-op scoreboard and stall generation.
// Operand select and stall are combinational; state is per-edge.
`ifndef ZeroReg
`define ZeroReg 5'd0
`endif

module fwd_hazard_unit
  import type_pkg::*;
#(
  parameter int NUM_RPORTS = 2,
  parameter int NUM_STAGES = 3,
  parameter int MAX_OUTST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_RPORTS-1:0] src_valid_i,
  input  RegAddrBus [NUM_RPORTS-1:0] src_addr_i,
  output RegAddrBus [NUM_RPORTS-1:0] rf_raddr_o,
  input  RegBus [NUM_RPORTS-1:0]     rf_rdata_i,
  output RegBus [NUM_RPORTS-1:0]     op_data_o,
  input  logic [NUM_STAGES-1:0] fwd_valid_i,
  input  RegAddrBus [NUM_STAGES-1:0] fwd_addr_i,
  input  RegBus [NUM_STAGES-1:0]     fwd_data_i,
  input  logic [NUM_STAGES-1:0] fwd_rdy_i,
  input  logic                  iss_valid_i,
  input  logic                  iss_long_i,
  input  RegAddrBus             iss_addr_i,
  input  logic                  lw_done_i,
  input  RegAddrBus             lw_addr_i,
  input  RegBus                 lw_data_i,
  output logic                  stall_o,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
  output logic [31:0]           stall_cnt_o,
  output logic                  err_o
);

  localparam int OutstW = $clog2(MAX_OUTST + 1);

  logic [NumRegs-1:1]    busy_q;
  logic [NumRegs-1:1]    busy_d;
  logic [NumRegs-1:0]    busy;
  logic [NUM_RPORTS-1:0] port_haz;
  logic [OutstW-1:0]     outst_q;
  logic [OutstW-1:0]     outst_d;
  logic [31:0]           cnt_q;
  logic                  err_q;

  logic long_req;
  logic outst_full;
  logic lw_on_iss;
  logic waw;
  logic fire;
  logic done_ok;
  logic done_bad;

  assign busy = {busy_q, 1'b0};

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
    fwd_port_mux #(
      .NUM_STAGES(NUM_STAGES)
    ) u_mux (
      .src_valid(src_valid_i[p]),
      .src_addr (src_addr_i[p]),
      .rf_rdata (rf_rdata_i[p]),
      .rf_raddr (rf_raddr_o[p]),
      .op_data  (op_data_o[p]),
      .hazard   (port_haz[p]),
      .fwd_valid(fwd_valid_i),
      .fwd_addr (fwd_addr_i),
      .fwd_data (fwd_data_i),
      .fwd_rdy  (fwd_rdy_i),
      .lw_done  (lw_done_i),
      .lw_addr  (lw_addr_i),
      .lw_data  (lw_data_i),
      .busy     (busy)
    );
  end

  // A completing write-back frees a slot in the same cycle.
  assign long_req   = iss_valid_i && iss_long_i;
  assign outst_full = (outst_q == OutstW'(MAX_OUTST)) && !lw_done_i;
  assign lw_on_iss  = lw_done_i && (lw_addr_i == iss_addr_i);
  assign waw        = busy[iss_addr_i] && !lw_on_iss;

  assign stall_o = (|port_haz) ||
                   (long_req && (outst_full || waw));

  assign fire     = long_req && !stall_o &&
                    (iss_addr_i != `ZeroReg);
  assign done_ok  = lw_done_i && busy[lw_addr_i];
  assign done_bad = lw_done_i && !busy[lw_addr_i];

  // Set after clear, so a same-register reissue stays busy.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NumRegs; r++) begin
      if (done_ok && (lw_addr_i == RegAddrBus'(r)))
        busy_d[r] = 1'b0;
      if (fire && (iss_addr_i == RegAddrBus'(r)))
        busy_d[r] = 1'b1;
    end
  end

  always_comb begin
    outst_d = outst_q;
    unique case ({fire, done_ok})
      2'b10:   outst_d = outst_q + OutstW'(1);
      2'b01:   outst_d = outst_q - OutstW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      outst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      outst_q <= outst_d;
      if (stall_o && (cnt_q != '1))
        cnt_q <= cnt_q + 32'd1;
      if (done_bad)
        err_q <= 1'b1;
    end
  end

  assign outst_o     = outst_q;
  assign stall_cnt_o = cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: vector table, directed sequences,
// and random traffic against a register-level reference model.
module tb_fwd_hazard_unit;
  import type_pkg::*;

  localparam int NP = 2;
  localparam int NS = 3;
  localparam int MO = 4;
  localparam int OW = $clog2(MO + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NP-1:0]       src_valid;
  logic [NP-1:0][4:0]  src_addr;
  logic [NP-1:0][4:0]  rf_raddr;
  logic [NP-1:0][31:0] rf_rdata;
  logic [NP-1:0][31:0] op_data;
  logic [NS-1:0]       fwd_valid;
  logic [NS-1:0][4:0]  fwd_addr;
  logic [NS-1:0][31:0] fwd_data;
  logic [NS-1:0]       fwd_rdy;
  logic                iss_valid;
  logic                iss_long;
  logic [4:0]          iss_addr;
  logic                lw_done;
  logic [4:0]          lw_addr;
  logic [31:0]         lw_data;
  logic                stall;
  logic [OW-1:0]       outst;
  logic [31:0]         stall_cnt;
  logic                err;

  fwd_hazard_unit #(
    .NUM_RPORTS(NP),
    .NUM_STAGES(NS),
    .MAX_OUTST (MO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid_i(src_valid),
    .src_addr_i (src_addr),
    .rf_raddr_o (rf_raddr),
    .rf_rdata_i (rf_rdata),
    .op_data_o  (op_data),
    .fwd_valid_i(fwd_valid),
    .fwd_addr_i (fwd_addr),
    .fwd_data_i (fwd_data),
    .fwd_rdy_i  (fwd_rdy),
    .iss_valid_i(iss_valid),
    .iss_long_i (iss_long),
    .iss_addr_i (iss_addr),
    .lw_done_i  (lw_done),
    .lw_addr_i  (lw_addr),
    .lw_data_i  (lw_data),
    .stall_o    (stall),
    .outst_o    (outst),
    .stall_cnt_o(stall_cnt),
    .err_o      (err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    src_valid = '0;
    src_addr  = '0;
    rf_rdata  = '0;
    fwd_valid = '0;
    fwd_addr  = '0;
    fwd_data  = '0;
    fwd_rdy   = '1;
    iss_valid = 1'b0;
    iss_long  = 1'b0;
    iss_addr  = '0;
    lw_done   = 1'b0;
    lw_addr   = '0;
    lw_data   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vector table: combinational select with an empty scoreboard.
  typedef struct {
    logic [1:0]  sv;
    logic [4:0]  sa0, sa1;
    logic [31:0] rf0, rf1;
    logic [2:0]  fv, fr;
    logic [4:0]  fa0, fa1, fa2;
    logic [31:0] fd0, fd1, fd2;
    logic        lwd;
    logic [4:0]  lwa;
    logic [31:0] lwdat;
    logic [31:0] e_op0, e_op1;
    logic [4:0]  e_ra0, e_ra1;
    logic        e_stall;
  } vec_t;

  vec_t tbl[8];

  task automatic apply_vec(input vec_t v);
    idle();
    src_valid   = v.sv;
    src_addr[0] = v.sa0;
    src_addr[1] = v.sa1;
    rf_rdata[0] = v.rf0;
    rf_rdata[1] = v.rf1;
    fwd_valid   = v.fv;
    fwd_rdy     = v.fr;
    fwd_addr[0] = v.fa0;
    fwd_addr[1] = v.fa1;
    fwd_addr[2] = v.fa2;
    fwd_data[0] = v.fd0;
    fwd_data[1] = v.fd1;
    fwd_data[2] = v.fd2;
    lw_done     = v.lwd;
    lw_addr     = v.lwa;
    lw_data     = v.lwdat;
  endtask

  // Reference model state.
  bit          mbusy[32];
  int          mout;
  logic [31:0] mcnt;
  bit          merr;
  logic [31:0] exp_op[NP];
  logic [4:0]  exp_ra[NP];
  bit          exp_stall;
  bit          exp_fire;

  task automatic model_reset();
    foreach (mbusy[r]) mbusy[r] = 1'b0;
    mout = 0;
    mcnt = '0;
    merr = 1'b0;
  endtask

  task automatic model_comb();
    exp_stall = 1'b0;
    for (int p = 0; p < NP; p++) begin
      int a;
      int hs;
      bit lwh;
      a  = int'(src_addr[p]);
      hs = -1;
      for (int s = 0; s < NS; s++)
        if (hs < 0 && fwd_valid[s] && int'(fwd_addr[s]) == a)
          hs = s;
      lwh = lw_done && int'(lw_addr) == a;
      if (a == 0) begin
        exp_op[p] = rf_rdata[p];
        exp_ra[p] = 5'd0;
      end else if (hs >= 0) begin
        exp_op[p] = fwd_data[hs];
        exp_ra[p] = 5'd0;
        if (src_valid[p] && !fwd_rdy[hs]) exp_stall = 1'b1;
      end else if (lwh) begin
        exp_op[p] = lw_data;
        exp_ra[p] = 5'd0;
      end else begin
        exp_op[p] = rf_rdata[p];
        exp_ra[p] = src_addr[p];
        if (src_valid[p] && mbusy[a]) exp_stall = 1'b1;
      end
    end
    if (iss_valid && iss_long) begin
      if (mout == MO && !lw_done) exp_stall = 1'b1;
      if (mbusy[iss_addr] && !(lw_done && lw_addr == iss_addr))
        exp_stall = 1'b1;
    end
    exp_fire = iss_valid && iss_long && !exp_stall && iss_addr != 0;
  endtask

  task automatic model_edge();
    bit dv;
    dv = lw_done && lw_addr != 0 && mbusy[lw_addr];
    if (lw_done && !dv) merr = 1'b1;
    if (dv) mbusy[lw_addr] = 1'b0;
    if (exp_fire) mbusy[iss_addr] = 1'b1;
    mout = mout + int'(exp_fire) - int'(dv);
    if (exp_stall && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{2'b11, 5'd5, 5'd6, 32'h50, 32'h66, 3'b011, 3'b111,
               5'd5, 5'd5, 5'd0, 32'hA, 32'hB, 32'h0, 1'b0, 5'd0,
               32'h0, 32'hA, 32'h66, 5'd0, 5'd6, 1'b0};
    tbl[1] = '{2'b11, 5'd3, 5'd0, 32'h33, 32'h11, 3'b001, 3'b111,
               5'd0, 5'd0, 5'd0, 32'h55, 32'h0, 32'h0, 1'b0, 5'd0,
               32'h0, 32'h33, 32'h11, 5'd3, 5'd0, 1'b0};
    tbl[2] = '{2'b11, 5'd7, 5'd8, 32'h70, 32'h80, 3'b001, 3'b110,
               5'd7, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0, 1'b0, 5'd0,
               32'h0, 32'h77, 32'h80, 5'd0, 5'd8, 1'b1};
    tbl[3] = '{2'b01, 5'd4, 5'd0, 32'h44, 32'h11, 3'b011, 3'b101,
               5'd4, 5'd4, 5'd0, 32'h40, 32'h41, 32'h0, 1'b0, 5'd0,
               32'h0, 32'h40, 32'h11, 5'd0, 5'd0, 1'b0};
    tbl[4] = '{2'b10, 5'd1, 5'd2, 32'h10, 32'h20, 3'b100, 3'b111,
               5'd0, 5'd0, 5'd2, 32'h0, 32'h0, 32'h222, 1'b0, 5'd0,
               32'h0, 32'h10, 32'h222, 5'd1, 5'd0, 1'b0};
    tbl[5] = '{2'b11, 5'd9, 5'd11, 32'h90, 32'hB0, 3'b010, 3'b111,
               5'd0, 5'd11, 5'd0, 32'h0, 32'hBB, 32'h0, 1'b1, 5'd9,
               32'h1234, 32'h1234, 32'hBB, 5'd0, 5'd0, 1'b0};
    tbl[6] = '{2'b10, 5'd0, 5'd11, 32'h1, 32'hB0, 3'b100, 3'b111,
               5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'hCAFE, 1'b1, 5'd11,
               32'hDEAD, 32'h1, 32'hCAFE, 5'd0, 5'd0, 1'b0};
    tbl[7] = '{2'b00, 5'd7, 5'd3, 32'h70, 32'h30, 3'b001, 3'b110,
               5'd7, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0, 1'b0, 5'd0,
               32'h0, 32'h77, 32'h30, 5'd0, 5'd3, 1'b0};

    rst_n = 1'b0;
    idle();
    tick();
    chk("rst.outst", 32'(outst), 32'd0);
    chk("rst.stall_cnt", stall_cnt, 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply_vec(tbl[i]);
      #1;
      chk($sformatf("vec%0d.op0", i), op_data[0], tbl[i].e_op0);
      chk($sformatf("vec%0d.op1", i), op_data[1], tbl[i].e_op1);
      chk($sformatf("vec%0d.ra0", i), 32'(rf_raddr[0]), 32'(tbl[i].e_ra0));
      chk($sformatf("vec%0d.ra1", i), 32'(rf_raddr[1]), 32'(tbl[i].e_ra1));
      chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(tbl[i].e_stall));
      tick();
    end
    idle();
    #1;
    chk("vec.stall_cnt", stall_cnt, 32'd1);
    chk("vec.err", 32'(err), 32'd1);

    do_reset();

    // Not-ready stage data: one stall cycle.
    src_valid   = 2'b01;
    src_addr[0] = 5'd7;
    fwd_valid   = 3'b001;
    fwd_addr[0] = 5'd7;
    fwd_data[0] = 32'h77;
    fwd_rdy     = 3'b110;
    #1;
    chk("ld.stall", 32'(stall), 32'd1);
    tick();
    chk("ld.cnt", stall_cnt, 32'd1);
    fwd_rdy = 3'b111;
    #1;
    chk("ld.stall_off", 32'(stall), 32'd0);
    chk("ld.op0", op_data[0], 32'h77);
    tick();
    chk("ld.cnt_hold", stall_cnt, 32'd1);

    // Long op on x9, dependent read, write-back bypass.
    idle();
    iss_valid = 1'b1;
    iss_long  = 1'b1;
    iss_addr  = 5'd9;
    #1;
    chk("lo.iss_stall", 32'(stall), 32'd0);
    tick();
    chk("lo.outst1", 32'(outst), 32'd1);
    idle();
    src_valid   = 2'b01;
    src_addr[0] = 5'd9;
    rf_rdata[0] = 32'h99;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("lo.stall%0d", c), 32'(stall), 32'd1);
      tick();
    end
    chk("lo.cnt", stall_cnt, 32'd4);
    lw_done = 1'b1;
    lw_addr = 5'd9;
    lw_data = 32'h1234;
    #1;
    chk("lo.byp_op", op_data[0], 32'h1234);
    chk("lo.byp_stall", 32'(stall), 32'd0);
    chk("lo.byp_ra", 32'(rf_raddr[0]), 32'd0);
    tick();
    chk("lo.outst0", 32'(outst), 32'd0);
    lw_done = 1'b0;
    #1;
    chk("lo.free_stall", 32'(stall), 32'd0);
    chk("lo.free_ra", 32'(rf_raddr[0]), 32'd9);

    // Fill MAX_OUTST slots, then a fifth issue.
    idle();
    for (int a = 1; a <= MO; a++) begin
      iss_valid = 1'b1;
      iss_long  = 1'b1;
      iss_addr  = 5'(a);
      #1;
      chk($sformatf("fill.stall%0d", a), 32'(stall), 32'd0);
      tick();
    end
    chk("fill.outst", 32'(outst), 32'd4);
    iss_addr = 5'd5;
    #1;
    chk("full.stall", 32'(stall), 32'd1);
    tick();
    chk("full.outst", 32'(outst), 32'd4);
    chk("full.cnt", stall_cnt, 32'd5);
    lw_done = 1'b1;
    lw_addr = 5'd1;
    #1;
    chk("swap.stall", 32'(stall), 32'd0);
    tick();
    chk("swap.outst", 32'(outst), 32'd4);
    chk("swap.err", 32'(err), 32'd0);
    idle();
    src_valid   = 2'b01;
    src_addr[0] = 5'd1;
    #1;
    chk("swap.x1_free", 32'(stall), 32'd0);
    src_valid   = 2'b10;
    src_addr[1] = 5'd5;
    #1;
    chk("swap.x5_busy", 32'(stall), 32'd1);

    // Reissue x3 while its write-back lands: set wins.
    idle();
    iss_valid = 1'b1;
    iss_long  = 1'b1;
    iss_addr  = 5'd3;
    lw_done   = 1'b1;
    lw_addr   = 5'd3;
    #1;
    chk("sw.stall", 32'(stall), 32'd0);
    tick();
    chk("sw.outst", 32'(outst), 32'd4);
    idle();
    src_valid   = 2'b01;
    src_addr[0] = 5'd3;
    #1;
    chk("sw.x3_busy", 32'(stall), 32'd1);

    // WAW with a free slot.
    idle();
    lw_done = 1'b1;
    lw_addr = 5'd4;
    tick();
    chk("waw.outst3", 32'(outst), 32'd3);
    idle();
    iss_valid = 1'b1;
    iss_long  = 1'b1;
    iss_addr  = 5'd2;
    #1;
    chk("waw.stall", 32'(stall), 32'd1);
    tick();
    chk("waw.outst", 32'(outst), 32'd3);

    // Spurious write-back, sticky error, mid-run reset.
    idle();
    lw_done = 1'b1;
    lw_addr = 5'd12;
    tick();
    chk("err.set", 32'(err), 32'd1);
    chk("err.outst", 32'(outst), 32'd3);
    idle();
    tick();
    chk("err.sticky", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst.outst", 32'(outst), 32'd0);
    chk("mrst.err", 32'(err), 32'd0);
    chk("mrst.cnt", stall_cnt, 32'd0);
    src_valid   = 2'b01;
    src_addr[0] = 5'd5;
    #1;
    chk("mrst.x5_free", 32'(stall), 32'd0);
    tick();
    rst_n   = 1'b1;
    idle();
    lw_done = 1'b1;
    lw_addr = 5'd5;
    tick();
    chk("mrst.late_err", 32'(err), 32'd1);
    chk("mrst.late_outst", 32'(outst), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int q[$];
      if (n == 1500) do_reset();
      src_valid = 2'($urandom);
      for (int p = 0; p < NP; p++) begin
        src_addr[p] = 5'($urandom_range(0, 7));
        rf_rdata[p] = $urandom;
      end
      for (int s = 0; s < NS; s++) begin
        fwd_valid[s] = 1'($urandom);
        fwd_addr[s]  = 5'($urandom_range(0, 7));
        fwd_data[s]  = $urandom;
        fwd_rdy[s]   = ($urandom_range(0, 3) != 0);
      end
      iss_valid = 1'($urandom);
      iss_long  = 1'($urandom);
      iss_addr  = 5'($urandom_range(0, 7));
      lw_done   = ($urandom_range(0, 2) == 0);
      lw_data   = $urandom;
      lw_addr   = 5'($urandom_range(0, 7));
      for (int r = 1; r < 32; r++) if (mbusy[r]) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 4) != 0)
        lw_addr = 5'(q[$urandom_range(0, q.size() - 1)]);
      #1;
      model_comb();
      chk("rnd.op0", op_data[0], exp_op[0]);
      chk("rnd.op1", op_data[1], exp_op[1]);
      chk("rnd.ra0", 32'(rf_raddr[0]), 32'(exp_ra[0]));
      chk("rnd.ra1", 32'(rf_raddr[1]), 32'(exp_ra[1]));
      chk("rnd.stall", 32'(stall), 32'(exp_stall));
      tick();
      model_edge();
      chk("rnd.outst", 32'(outst), 32'(mout));
      chk("rnd.cnt", stall_cnt, mcnt);
      chk("rnd.err", 32'(err), 32'(merr));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
